// File: rtl/eda_pkg.sv
// Shared types and window/mask index constants for the regional-maximum engine.
package eda_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, DRAIN} scan_state_e;

  // Window slice indices: MSB slice is upper-left, LSB slice is lower-right.
  localparam int WIN_UL = 8, WIN_U = 7, WIN_UR = 6, WIN_L = 5, WIN_C = 4;
  localparam int WIN_R  = 3, WIN_DL = 2, WIN_D = 1, WIN_DR = 0;

  // Neighbour-valid mask bits. This ordering is the window ordering with the center removed.
  localparam int NB_UL = 7, NB_U = 6, NB_UR = 5, NB_L = 4;
  localparam int NB_R  = 3, NB_DL = 2, NB_D = 1, NB_DR = 0;

  function automatic int nb2win(input int k);
    return (k >= NB_L) ? k + 1 : k;
  endfunction

endpackage

// File: rtl/eda_win_cmp.sv
// Combinational 3x3 local-maximum test: center vs. every masked-in neighbour.
// i_strict selects > (plateaus rejected) instead of >=.
module eda_win_cmp
  import eda_pkg::*;
#(
  parameter int PIXEL_WIDTH  = 8,
  parameter int WINDOW_WIDTH = 9
) (
  input  logic [PIXEL_WIDTH*WINDOW_WIDTH-1:0] i_window,
  input  logic [WINDOW_WIDTH-2:0]             i_mask,
  input  logic                                i_strict,
  output logic                                o_flag
);

  logic [PIXEL_WIDTH-1:0]  w_c;
  logic [WINDOW_WIDTH-2:0] w_ok;

  assign w_c = i_window[WIN_C*PIXEL_WIDTH +: PIXEL_WIDTH];

  for (genvar k = 0; k < WINDOW_WIDTH-1; k++) begin : g_nb
    localparam int S = nb2win(k);
    logic [PIXEL_WIDTH-1:0] w_nb;
    assign w_nb    = i_window[S*PIXEL_WIDTH +: PIXEL_WIDTH];
    assign w_ok[k] = !i_mask[k] || (i_strict ? (w_c > w_nb) : (w_c >= w_nb));
  end

  assign o_flag = &w_ok;

endmodule

// File: rtl/eda_scan_ctrl.sv
// Frame load + window scan sequencer for the image window RAM.
// Define EDA_SCAN_STRICT_MAX_EN to use a strict > compare, so plateaus are not flagged.
module eda_scan_ctrl
  import eda_pkg::*;
#(
  parameter int M            = 16,
  parameter int N            = 16,
  parameter int PIXEL_WIDTH  = 8,
  parameter int WINDOW_WIDTH = 9,
  parameter int I_WIDTH      = $clog2(N),
  parameter int J_WIDTH      = $clog2(M),
  parameter int ADDR_WIDTH   = I_WIDTH + J_WIDTH
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [PIXEL_WIDTH-1:0]              s_pixel,
  output logic                                ram_write_en,
  output logic [ADDR_WIDTH-1:0]               ram_wr_addr,
  output logic [PIXEL_WIDTH-1:0]              ram_pixel_in,
  output logic [ADDR_WIDTH-1:0]               ram_center_addr,
  input  logic [PIXEL_WIDTH*WINDOW_WIDTH-1:0] ram_window_values,
  input  logic [WINDOW_WIDTH-2:0]             ram_neigh_valid,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [ADDR_WIDTH-1:0]               m_addr,
  output logic                                m_flag
);

  localparam logic [I_WIDTH-1:0] LAST_I = I_WIDTH'(N-1);
  localparam logic [J_WIDTH-1:0] LAST_J = J_WIDTH'(M-1);
`ifdef EDA_SCAN_STRICT_MAX_EN
  localparam logic STRICT = 1'b1;
`else
  localparam logic STRICT = 1'b0;
`endif

  scan_state_e           r_state;
  logic [I_WIDTH-1:0]    r_i;
  logic [J_WIDTH-1:0]    r_j;
  logic                  r_done;
  logic                  r_m_valid;
  logic                  r_m_flag;
  logic [ADDR_WIDTH-1:0] r_m_addr;

  logic [I_WIDTH-1:0]    w_i_nxt;
  logic [J_WIDTH-1:0]    w_j_nxt;
  logic                  w_last, w_hs, w_take, w_flag;

  // One {i,j} counter pair serves both phases: load address, then scan center.
  always_comb begin
    w_i_nxt = r_i;
    w_j_nxt = r_j + 1'b1;
    if (r_j == LAST_J) begin
      w_j_nxt = '0;
      w_i_nxt = r_i + 1'b1;
    end
  end

  assign w_last          = (r_i == LAST_I) && (r_j == LAST_J);
  assign busy            = (r_state != IDLE);
  assign s_ready         = (r_state == LOAD);
  assign w_hs            = s_valid & s_ready;
  assign ram_write_en    = w_hs;
  assign ram_wr_addr     = {r_i, r_j};
  assign ram_pixel_in    = s_pixel;
  assign ram_center_addr = {r_i, r_j};
  assign w_take          = (r_state == SCAN) && (!r_m_valid || m_ready);
  assign done            = r_done;
  assign m_valid         = r_m_valid;
  assign m_addr          = r_m_addr;
  assign m_flag          = r_m_flag;

  eda_win_cmp #(
    .PIXEL_WIDTH (PIXEL_WIDTH),
    .WINDOW_WIDTH(WINDOW_WIDTH)
  ) u_cmp (
    .i_window(ram_window_values),
    .i_mask  (ram_neigh_valid),
    .i_strict(STRICT),
    .o_flag  (w_flag)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_i       <= '0;
      r_j       <= '0;
      r_done    <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_flag  <= 1'b0;
      r_m_addr  <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_m_valid && m_ready) r_m_valid <= 1'b0;
      unique case (r_state)
        IDLE: if (start) begin
          r_state <= LOAD;
          r_i     <= '0;
          r_j     <= '0;
        end
        LOAD: if (w_hs) begin
          if (w_last) begin
            r_state <= SCAN;
            r_i     <= '0;
            r_j     <= '0;
          end else begin
            r_i <= w_i_nxt;
            r_j <= w_j_nxt;
          end
        end
        SCAN: if (w_take) begin
          r_m_valid <= 1'b1;
          r_m_addr  <= {r_i, r_j};
          r_m_flag  <= w_flag;
          if (w_last) r_state <= DRAIN;
          else begin
            r_i <= w_i_nxt;
            r_j <= w_j_nxt;
          end
        end
        DRAIN: if (r_m_valid && m_ready) begin
          r_state <= IDLE;
          r_done  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
